rggen_apb_adapter_v2: RTL and testbench

RGGEN_APB_ADAPTER_V2 -- requirements
Module: rggen_apb_adapter_v2

---
 rtl/rggen_apb_adapter_v2.sv | 175 +++++++++++++++++
 tb/tb_rggen_apb_adapter_v2.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rggen_apb_adapter_v2.sv
// APB slave to rggen register-bus adapter: address window and protection checks,
// one-wait-state handshake, optional access timeout.
module rggen_apb_adapter_v2 #(
  parameter int                     ADDRESS_WIDTH       = 8,
  parameter int                     LOCAL_ADDRESS_WIDTH = 8,
  parameter int                     BUS_WIDTH           = 32,
  parameter int                     REGISTERS           = 1,
  parameter bit [ADDRESS_WIDTH-1:0] BASE_ADDRESS        = '0,
  parameter int unsigned            BYTE_SIZE           = 256,
  parameter bit                     ERROR_STATUS        = 1'b0,
  parameter bit [BUS_WIDTH-1:0]     DEFAULT_READ_DATA   = '0,
  parameter int                     TIMEOUT_CYCLES      = 0,
  parameter bit                     PRIVILEGED_ONLY     = 1'b0,
  parameter bit                     SECURE_ONLY         = 1'b0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_psel,
  input  logic                           i_penable,
  input  logic                           i_pwrite,
  input  logic [ADDRESS_WIDTH-1:0]       i_paddr,
  input  logic [2:0]                     i_pprot,
  input  logic [BUS_WIDTH/8-1:0]         i_pstrb,
  input  logic [BUS_WIDTH-1:0]           i_pwdata,
  output logic                           o_pready,
  output logic [BUS_WIDTH-1:0]           o_prdata,
  output logic                           o_pslverr,
  output logic                           o_timeout,
  output logic                           o_register_valid,
  output logic [1:0]                     o_register_access,
  output logic [LOCAL_ADDRESS_WIDTH-1:0] o_register_address,
  output logic [BUS_WIDTH-1:0]           o_register_write_data,
  output logic [BUS_WIDTH/8-1:0]         o_register_strobe,
  input  logic [REGISTERS-1:0]           i_register_active,
  input  logic [REGISTERS-1:0]           i_register_ready,
  input  logic [2*REGISTERS-1:0]         i_register_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

  localparam int STRB_W   = BUS_WIDTH / 8;
  localparam int LSB      = $clog2(STRB_W);
  localparam int CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CNT_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [LOCAL_ADDRESS_WIDTH-1:0] ALIGN_MASK =
    ~LOCAL_ADDRESS_WIDTH'((64'd1 << LSB) - 64'd1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_e;

  state_e                   state_q;
  logic [ADDRESS_WIDTH-1:0] paddr_q;
  logic                     write_q;
  logic [BUS_WIDTH-1:0]     wdata_q;
  logic [STRB_W-1:0]        strb_q;
  logic [2:0]               prot_q;
  logic [CNT_W-1:0]         count_q;
  logic                     valid_q;
  logic                     pready_q;
  logic                     pslverr_q;
  logic                     timeout_q;
  logic [BUS_WIDTH-1:0]     prdata_q;

  logic [BUS_WIDTH-1:0]     rdata_d;
  logic                     rerror_d;
  logic                     prot_ok;
  logic                     in_range;
  logic                     ready_hit;
  logic                     any_active;
  logic                     timeout_hit;
  logic [ADDRESS_WIDTH-1:0] offset;
  logic                     unused_ok;

  // AND-OR mux: only the register that claims the access contributes.
  always_comb begin
    rdata_d  = '0;
    rerror_d = 1'b0;
    for (int i = 0; i < REGISTERS; i++) begin
      rdata_d  = rdata_d | (i_register_read_data[i*BUS_WIDTH +: BUS_WIDTH] &
                            {BUS_WIDTH{i_register_active[i]}});
      rerror_d = rerror_d | (i_register_status[2*i+1] & i_register_active[i]);
    end
  end

  assign prot_ok     = !((PRIVILEGED_ONLY && !i_pprot[0]) || (SECURE_ONLY && i_pprot[1]));
  // Wrap-around subtraction makes addresses below the base fall out of range too.
  assign in_range    = (64'(i_paddr) - 64'(BASE_ADDRESS)) < 64'(BYTE_SIZE);
  assign ready_hit   = |(i_register_active & i_register_ready);
  assign any_active  = |i_register_active;
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (count_q == CNT_W'(CNT_LAST));
  assign offset      = paddr_q - BASE_ADDRESS;
  assign unused_ok   = ^{i_penable, prot_q, i_register_status};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prot_q    <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      timeout_q <= 1'b0;
      prdata_q  <= DEFAULT_READ_DATA;
    end else begin
      pready_q  <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_psel) begin
            paddr_q <= i_paddr;
            write_q <= i_pwrite;
            wdata_q <= i_pwdata;
            strb_q  <= i_pstrb;
            prot_q  <= i_pprot;
            if (!prot_ok) begin
              state_q   <= RESPOND;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
              prdata_q  <= DEFAULT_READ_DATA;
            end else if (!in_range) begin
              state_q   <= RESPOND;
              pready_q  <= 1'b1;
              pslverr_q <= ERROR_STATUS;
              prdata_q  <= DEFAULT_READ_DATA;
            end else begin
              state_q <= ACCESS;
              valid_q <= 1'b1;
              count_q <= '0;
            end
          end
        end
        ACCESS: begin
          if (!any_active) begin
            state_q   <= RESPOND;
            valid_q   <= 1'b0;
            pready_q  <= 1'b1;
            pslverr_q <= ERROR_STATUS;
            prdata_q  <= DEFAULT_READ_DATA;
          end else if (ready_hit) begin
            state_q   <= RESPOND;
            valid_q   <= 1'b0;
            pready_q  <= 1'b1;
            pslverr_q <= rerror_d;
            prdata_q  <= write_q ? DEFAULT_READ_DATA : rdata_d;
          end else if (timeout_hit) begin
            state_q   <= RESPOND;
            valid_q   <= 1'b0;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
            timeout_q <= 1'b1;
            prdata_q  <= DEFAULT_READ_DATA;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_pready              = pready_q;
  assign o_prdata              = prdata_q;
  assign o_pslverr             = pslverr_q;
  assign o_timeout             = timeout_q;
  assign o_register_valid      = valid_q;
  assign o_register_access     = {1'b1, write_q};
  assign o_register_address    = LOCAL_ADDRESS_WIDTH'(offset) & ALIGN_MASK;
  assign o_register_write_data = wdata_q;
  assign o_register_strobe     = strb_q;

endmodule

// File: tb/tb_rggen_apb_adapter_v2.sv
// Directed bench: two adapter instances share one stimulus stream; A is strict
// (privileged-only, erroring window, timeout 4), B is permissive.
module tb_rggen_apb_adapter_v2;

  localparam logic [31:0] DEF = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [2:0]  pprot = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] pwdata = '0;
  logic [1:0]  active = '0, ready = '0;
  logic [3:0]  status = '0;
  logic [63:0] rdata = '0;

  logic        aPready, aPslverr, aTimeout, aValid;
  logic [31:0] aPrdata, aWdata;
  logic [1:0]  aAccess;
  logic [7:0]  aAddr;
  logic [3:0]  aStrobe;
  logic        bPready, bPslverr, bTimeout, bValid;
  logic [31:0] bPrdata, bWdata;
  logic [1:0]  bAccess;
  logic [7:0]  bAddr;
  logic [3:0]  bStrobe;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rggen_apb_adapter_v2 #(
    .ADDRESS_WIDTH(8), .LOCAL_ADDRESS_WIDTH(8), .BUS_WIDTH(32), .REGISTERS(2),
    .BASE_ADDRESS(8'h00), .BYTE_SIZE(64), .ERROR_STATUS(1'b1), .DEFAULT_READ_DATA(DEF),
    .TIMEOUT_CYCLES(4), .PRIVILEGED_ONLY(1'b1), .SECURE_ONLY(1'b0)
  ) dutA (
    .i_clk(clk), .i_rst(rst), .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite),
    .i_paddr(paddr), .i_pprot(pprot), .i_pstrb(pstrb), .i_pwdata(pwdata),
    .o_pready(aPready), .o_prdata(aPrdata), .o_pslverr(aPslverr), .o_timeout(aTimeout),
    .o_register_valid(aValid), .o_register_access(aAccess), .o_register_address(aAddr),
    .o_register_write_data(aWdata), .o_register_strobe(aStrobe),
    .i_register_active(active), .i_register_ready(ready), .i_register_status(status),
    .i_register_read_data(rdata)
  );

  rggen_apb_adapter_v2 #(
    .ADDRESS_WIDTH(8), .LOCAL_ADDRESS_WIDTH(8), .BUS_WIDTH(32), .REGISTERS(2),
    .BASE_ADDRESS(8'h00), .BYTE_SIZE(64), .ERROR_STATUS(1'b0), .DEFAULT_READ_DATA(DEF),
    .TIMEOUT_CYCLES(0), .PRIVILEGED_ONLY(1'b0), .SECURE_ONLY(1'b0)
  ) dutB (
    .i_clk(clk), .i_rst(rst), .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite),
    .i_paddr(paddr), .i_pprot(pprot), .i_pstrb(pstrb), .i_pwdata(pwdata),
    .o_pready(bPready), .o_prdata(bPrdata), .o_pslverr(bPslverr), .o_timeout(bTimeout),
    .o_register_valid(bValid), .o_register_access(bAccess), .o_register_address(bAddr),
    .o_register_write_data(bWdata), .o_register_strobe(bStrobe),
    .i_register_active(active), .i_register_ready(ready), .i_register_status(status),
    .i_register_read_data(rdata)
  );

  // Advance to just after the next rising edge, where inputs change and outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sel, input logic en, input logic wr,
                               input logic [7:0] addr, input logic [2:0] prot,
                               input logic [3:0] strb, input logic [31:0] wd);
    psel = sel; penable = en; pwrite = wr; paddr = addr;
    pprot = prot; pstrb = strb; pwdata = wd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    tick(); tick();
    checkOutput("rst_pready_A", 32'(aPready), 32'd0);
    checkOutput("rst_pslverr_A", 32'(aPslverr), 32'd0);
    checkOutput("rst_timeout_A", 32'(aTimeout), 32'd0);
    checkOutput("rst_valid_A", 32'(aValid), 32'd0);
    checkOutput("rst_prdata_A", aPrdata, DEF);
    checkOutput("rst_addr_A", 32'(aAddr), 32'd0);
    rst = 1'b0;

    // Read 0x04 served by register 1 on the first ACCESS cycle
    rdata = {32'hDEADBEEF, 32'h0000_1111};
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h04, 3'b001, 4'hF, 32'h0);
    checkOutput("rd_c0_valid_A", 32'(aValid), 32'd0);
    tick();
    checkOutput("rd_c1_valid_A", 32'(aValid), 32'd1);
    checkOutput("rd_c1_valid_B", 32'(bValid), 32'd1);
    checkOutput("rd_c1_access_A", 32'(aAccess), 32'h2);
    checkOutput("rd_c1_addr_A", 32'(aAddr), 32'h04);
    checkOutput("rd_c1_pready_A", 32'(aPready), 32'd0);
    penable = 1'b1; active = 2'b10; ready = 2'b10;
    tick();
    checkOutput("rd_c2_pready_A", 32'(aPready), 32'd1);
    checkOutput("rd_c2_prdata_A", aPrdata, 32'hDEADBEEF);
    checkOutput("rd_c2_pslverr_A", 32'(aPslverr), 32'd0);
    checkOutput("rd_c2_valid_A", 32'(aValid), 32'd0);
    checkOutput("rd_c2_prdata_B", bPrdata, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 4'h0, 32'h0);
    active = 2'b00; ready = 2'b00;
    tick();
    checkOutput("rd_c3_pready_A", 32'(aPready), 32'd0);
    checkOutput("rd_c3_hold_A", aPrdata, 32'hDEADBEEF);

    // Write 0x08 with partial strobe
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h08, 3'b001, 4'b0011, 32'hCAFE1234);
    tick();
    checkOutput("wr_access_A", 32'(aAccess), 32'h3);
    checkOutput("wr_addr_A", 32'(aAddr), 32'h08);
    checkOutput("wr_strobe_A", 32'(aStrobe), 32'h3);
    checkOutput("wr_wdata_A", aWdata, 32'hCAFE1234);
    penable = 1'b1; active = 2'b01; ready = 2'b01;
    tick();
    checkOutput("wr_pready_A", 32'(aPready), 32'd1);
    checkOutput("wr_prdata_A", aPrdata, DEF);
    checkOutput("wr_pslverr_A", 32'(aPslverr), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 4'h0, 32'h0);
    active = 2'b00; ready = 2'b00;
    tick();
    checkOutput("wr_pready_off_A", 32'(aPready), 32'd0);

    // Unaligned read 0x07 -> register address 0x04, one extra wait, status error
    rdata = {32'h0000_2222, 32'h5A5A0001};
    status = 4'b0010;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h07, 3'b001, 4'hF, 32'h0);
    tick();
    checkOutput("st_addr_A", 32'(aAddr), 32'h04);
    penable = 1'b1; active = 2'b01;
    tick();
    checkOutput("st_wait_valid_A", 32'(aValid), 32'd1);
    checkOutput("st_wait_pready_A", 32'(aPready), 32'd0);
    ready = 2'b01;
    tick();
    checkOutput("st_pready_A", 32'(aPready), 32'd1);
    checkOutput("st_pslverr_A", 32'(aPslverr), 32'd1);
    checkOutput("st_prdata_A", aPrdata, 32'h5A5A0001);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 4'h0, 32'h0);
    active = 2'b00; ready = 2'b00; status = 4'b0000;
    tick();

    // Unprivileged access: A rejects at cycle 1, B finds no active register
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h04, 3'b000, 4'hF, 32'h0);
    tick();
    checkOutput("prot_pready_A", 32'(aPready), 32'd1);
    checkOutput("prot_pslverr_A", 32'(aPslverr), 32'd1);
    checkOutput("prot_valid_A", 32'(aValid), 32'd0);
    checkOutput("prot_prdata_A", aPrdata, DEF);
    checkOutput("prot_valid_B", 32'(bValid), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 4'h0, 32'h0);
    tick();
    checkOutput("prot_c2_pready_A", 32'(aPready), 32'd0);
    checkOutput("prot_c2_valid_A", 32'(aValid), 32'd0);
    checkOutput("noact_pready_B", 32'(bPready), 32'd1);
    checkOutput("noact_pslverr_B", 32'(bPslverr), 32'd0);
    tick();

    // First address past the window
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h40, 3'b001, 4'hF, 32'h0);
    tick();
    checkOutput("rng_pready_A", 32'(aPready), 32'd1);
    checkOutput("rng_pslverr_A", 32'(aPslverr), 32'd1);
    checkOutput("rng_valid_A", 32'(aValid), 32'd0);
    checkOutput("rng_pready_B", 32'(bPready), 32'd1);
    checkOutput("rng_pslverr_B", 32'(bPslverr), 32'd0);
    checkOutput("rng_valid_B", 32'(bValid), 32'd0);
    checkOutput("rng_prdata_B", bPrdata, DEF);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 4'h0, 32'h0);
    tick();

    // Timeout: register active but never ready
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h04, 3'b001, 4'hF, 32'h0);
    tick();
    penable = 1'b1; active = 2'b01;
    for (int c = 1; c <= 4; c++) begin
      checkOutput($sformatf("to_c%0d_valid_A", c), 32'(aValid), 32'd1);
      checkOutput($sformatf("to_c%0d_pready_A", c), 32'(aPready), 32'd0);
      tick();
    end
    checkOutput("to_pready_A", 32'(aPready), 32'd1);
    checkOutput("to_pslverr_A", 32'(aPslverr), 32'd1);
    checkOutput("to_timeout_A", 32'(aTimeout), 32'd1);
    checkOutput("to_prdata_A", aPrdata, DEF);
    checkOutput("to_valid_A", 32'(aValid), 32'd0);
    checkOutput("to_valid_B", 32'(bValid), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 4'h0, 32'h0);
    active = 2'b00; rst = 1'b1;
    tick();
    checkOutput("to_pulse_end_A", 32'(aTimeout), 32'd0);
    checkOutput("to_rst_valid_B", 32'(bValid), 32'd0);
    rst = 1'b0;

    // Reset during the second ACCESS cycle, then a clean transfer
    rdata = {32'hDEADBEEF, 32'h1111_1111};
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h04, 3'b001, 4'hF, 32'h0);
    tick();
    penable = 1'b1; active = 2'b10;
    tick();
    checkOutput("mr_c2_valid_A", 32'(aValid), 32'd1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 4'h0, 32'h0);
    active = 2'b00;
    tick();
    checkOutput("mr_valid_A", 32'(aValid), 32'd0);
    checkOutput("mr_pready_A", 32'(aPready), 32'd0);
    checkOutput("mr_valid_B", 32'(bValid), 32'd0);
    checkOutput("mr_pready_B", 32'(bPready), 32'd0);
    checkOutput("mr_prdata_A", aPrdata, DEF);
    rst = 1'b0;
    tick();
    checkOutput("mr_idle_pready_A", 32'(aPready), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h0C, 3'b001, 4'hF, 32'h0);
    tick();
    checkOutput("post_valid_A", 32'(aValid), 32'd1);
    checkOutput("post_addr_A", 32'(aAddr), 32'h0C);
    penable = 1'b1; active = 2'b01; ready = 2'b01;
    tick();
    checkOutput("post_pready_A", 32'(aPready), 32'd1);
    checkOutput("post_prdata_A", aPrdata, 32'h1111_1111);
    checkOutput("post_pslverr_A", 32'(aPslverr), 32'd0);
    checkOutput("post_pready_B", 32'(bPready), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 4'h0, 32'h0);
    active = 2'b00; ready = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
